// File: rtl/raster_sampler.sv
// -----------------------------------------------------------------------------
// raster_sampler
//
// Raster-scan sequencer placed directly upstream of the RAM shim. It walks X/Y
// position counters across a line_len x line_cnt grid, X fastest. At each point
// it:
//   1. waits a settle time,
//   2. runs one ADC conversion over a 4-phase handshake,
//   3. pushes the sample to the shim over a 4-phase handshake.
// The scan stalls while the shim withholds its acknowledge, so no sample is
// lost under back-pressure.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-low
//   start         level: 1 runs a scan; 0 aborts a scan or acknowledges done
//   line_len      samples per line     (captured when a scan starts)
//   line_cnt      lines per scan       (captured when a scan starts)
//   settle        settle cycles/point  (captured when a scan starts)
//   x_pos, y_pos  current grid position (drive the X/Y DACs)
//   adc_arm       ADC conversion request
//   adc_finished  ADC conversion done; adc_data is valid while it is high
//   adc_data      ADC result
//   data          sample presented to the shim
//   data_commit   shim write request
//   finished      shim write acknowledge
//   busy          scan in progress
//   done          scan completed normally; held until start drops
// -----------------------------------------------------------------------------
module raster_sampler #(
  parameter int DAT_WID    = 24,
  parameter int CNT_WID    = 16,
  parameter int SETTLE_WID = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WID-1:0]    line_len,
  input  logic [CNT_WID-1:0]    line_cnt,
  input  logic [SETTLE_WID-1:0] settle,
  output logic [CNT_WID-1:0]    x_pos,
  output logic [CNT_WID-1:0]    y_pos,
  output logic                  adc_arm,
  input  logic                  adc_finished,
  input  logic [DAT_WID-1:0]    adc_data,
  output logic [DAT_WID-1:0]    data,
  output logic                  data_commit,
  input  logic                  finished,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE           = 3'd0;
  localparam logic [2:0] S_SETTLE         = 3'd1;
  localparam logic [2:0] S_MEASURE        = 3'd2;
  localparam logic [2:0] S_MEAS_RELEASE   = 3'd3;
  localparam logic [2:0] S_COMMIT         = 3'd4;
  localparam logic [2:0] S_COMMIT_RELEASE = 3'd5;
  localparam logic [2:0] S_ADVANCE        = 3'd6;
  localparam logic [2:0] S_DONE           = 3'd7;

  logic [2:0]            state;
  // Grid limits are stored as "last index" so ADVANCE compares directly.
  logic [CNT_WID-1:0]    x_last;
  logic [CNT_WID-1:0]    y_last;
  logic [SETTLE_WID-1:0] settle_q;
  logic [SETTLE_WID-1:0] settle_cnt;

  // NOTE: reset is tested inside the clocked block, so it is synchronous; every
  // register, including the captured configuration, gets a defined value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      x_pos       <= '0;
      y_pos       <= '0;
      adc_arm     <= 1'b0;
      data        <= '0;
      data_commit <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      x_last      <= '0;
      y_last      <= '0;
      settle_q    <= '0;
      settle_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // values registered at the previous edge, independent of statement order.
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            x_pos <= '0;
            y_pos <= '0;
            if (line_len == '0 || line_cnt == '0) begin
              // Empty grid: report completion without touching ADC or shim.
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              // The zero check above keeps these subtractions from wrapping.
              x_last     <= line_len - CNT_WID'(1);
              y_last     <= line_cnt - CNT_WID'(1);
              settle_q   <= settle;
              settle_cnt <= settle;
              busy       <= 1'b1;
              state      <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (!start) begin
            // Abort is safe here: no handshake is in flight.
            x_pos <= '0;
            y_pos <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_WID'(1);
          end else if (!adc_finished) begin
            // Only arm once the ADC has released its previous acknowledge.
            adc_arm <= 1'b1;
            state   <= S_MEASURE;
          end
        end

        S_MEASURE: begin
          if (adc_finished) begin
            data    <= adc_data;
            adc_arm <= 1'b0;
            state   <= S_MEAS_RELEASE;
          end
        end

        S_MEAS_RELEASE: begin
          // data_commit only rises after adc_arm has dropped, so the two
          // requests never overlap.
          if (!adc_finished) begin
            data_commit <= 1'b1;
            state       <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          // Unbounded wait: a full shim FIFO simply stretches this state.
          if (finished) begin
            data_commit <= 1'b0;
            state       <= S_COMMIT_RELEASE;
          end
        end

        S_COMMIT_RELEASE: begin
          if (!finished) begin
            state <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          if (!start) begin
            x_pos <= '0;
            y_pos <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (x_pos != x_last) begin
            x_pos      <= x_pos + CNT_WID'(1);
            settle_cnt <= settle_q;
            state      <= S_SETTLE;
          end else begin
            x_pos <= '0;
            if (y_pos == y_last) begin
              y_pos <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              y_pos      <= y_pos + CNT_WID'(1);
              settle_cnt <= settle_q;
              state      <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          // Holding here until start drops forces a 0->1 edge for a new scan.
          if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_sampler.sv
// -----------------------------------------------------------------------------
// tb_raster_sampler
//
// Directed bench for raster_sampler. A negedge-driven environment process
// models the ADC (acks each arm with an incrementing value) and the shim
// (acks each commit after a programmable delay, with an optional long stall on
// one chosen sample), records every committed sample with its position, and
// counts request pulses. Scenario tasks drive inputs at posedge+1 and read
// results at negedge+1, comparing against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_raster_sampler;

  localparam int DAT_WID    = 24;
  localparam int CNT_WID    = 16;
  localparam int SETTLE_WID = 16;
  localparam int TIMEOUT    = 4000;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [CNT_WID-1:0]    line_len = '0;
  logic [CNT_WID-1:0]    line_cnt = '0;
  logic [SETTLE_WID-1:0] settle = '0;
  logic [CNT_WID-1:0]    x_pos;
  logic [CNT_WID-1:0]    y_pos;
  logic                  adc_arm;
  logic                  adc_finished = 1'b0;
  logic [DAT_WID-1:0]    adc_data = '0;
  logic [DAT_WID-1:0]    data;
  logic                  data_commit;
  logic                  finished = 1'b0;
  logic                  busy;
  logic                  done;

  // Environment knobs, written only by the scenario tasks.
  logic [DAT_WID-1:0] adc_seed = 24'd100;
  int                 adc_delay = 0;
  int                 shim_delay = 1;
  int                 stall_idx = -1;
  int                 stall_len = 0;
  logic               adc_hold_high = 1'b0;

  // Environment state, written only by the environment process.
  logic [DAT_WID-1:0] adc_next = '0;
  int                 adc_wait = 0;
  int                 shim_wait = 0;
  int                 need_wait = 0;
  int                 arm_pulses = 0;
  int                 commit_pulses = 0;
  int                 overlap_cnt = 0;
  int                 gap = 0;
  logic               arm_prev = 1'b0;
  logic               commit_prev = 1'b0;
  logic [DAT_WID-1:0] rec_data[$];
  int                 rec_x[$];
  int                 rec_y[$];
  int                 gaps[$];

  int n_checks = 0;
  int n_fail   = 0;

  raster_sampler #(
    .DAT_WID   (DAT_WID),
    .CNT_WID   (CNT_WID),
    .SETTLE_WID(SETTLE_WID)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .line_len    (line_len),
    .line_cnt    (line_cnt),
    .settle      (settle),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .adc_arm     (adc_arm),
    .adc_finished(adc_finished),
    .adc_data    (adc_data),
    .data        (data),
    .data_commit (data_commit),
    .finished    (finished),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // ADC + shim models and monitors. gap counts negedges since the shim last
  // released finished, and is logged at every adc_arm rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      adc_finished  = 1'b0;
      finished      = 1'b0;
      adc_next      = adc_seed;
      adc_wait      = 0;
      shim_wait     = 0;
      arm_pulses    = 0;
      commit_pulses = 0;
      overlap_cnt   = 0;
      gap           = 0;
      arm_prev      = 1'b0;
      commit_prev   = 1'b0;
      rec_data.delete();
      rec_x.delete();
      rec_y.delete();
      gaps.delete();
    end else begin
      gap = gap + 1;
      if (adc_arm && data_commit) overlap_cnt = overlap_cnt + 1;
      if (adc_arm && !arm_prev) begin
        arm_pulses = arm_pulses + 1;
        gaps.push_back(gap);
      end
      if (data_commit && !commit_prev) commit_pulses = commit_pulses + 1;
      arm_prev    = adc_arm;
      commit_prev = data_commit;

      if (adc_hold_high) begin
        adc_finished = 1'b1;
      end else if (adc_finished) begin
        if (!adc_arm) adc_finished = 1'b0;
      end else if (adc_arm) begin
        if (adc_wait >= adc_delay) begin
          adc_finished = 1'b1;
          adc_data     = adc_next;
          adc_next     = adc_next + 1'b1;
          adc_wait     = 0;
        end else begin
          adc_wait = adc_wait + 1;
        end
      end

      if (finished) begin
        if (!data_commit) begin
          finished = 1'b0;
          gap      = 0;
        end
      end else if (data_commit) begin
        need_wait = (rec_data.size() == stall_idx) ? stall_len : shim_delay;
        if (shim_wait >= need_wait) begin
          finished  = 1'b1;
          shim_wait = 0;
          rec_data.push_back(data);
          rec_x.push_back(int'(x_pos));
          rec_y.push_back(int'(y_pos));
        end else begin
          shim_wait = shim_wait + 1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_edge();
    rst   = 1'b0;
    start = 1'b0;
    drive_edge();
    drive_edge();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_commits(input int n, input string name);
    int t = 0;
    while (commit_pulses < n && t < TIMEOUT) begin tick(); t++; end
    n_checks++;
    if (commit_pulses < n) begin
      n_fail++;
      $display("FAIL %s: %0d commits seen, %0d required", name, commit_pulses, n);
    end
  endtask

  task automatic wait_arms(input int n, input string name);
    int t = 0;
    while (arm_pulses < n && t < TIMEOUT) begin tick(); t++; end
    n_checks++;
    if (arm_pulses < n) begin
      n_fail++;
      $display("FAIL %s: %0d arms seen, %0d required", name, arm_pulses, n);
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done !== 1'b1 && t < TIMEOUT) begin tick(); t++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, t);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({x_pos, y_pos, adc_arm, data, data_commit, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: x=%0d y=%0d arm=%b data=%h commit=%b busy=%b done=%b, required all 0",
               x_pos, y_pos, adc_arm, data, data_commit, busy, done);
    end
  endtask

  task automatic test_scan();
    adc_seed = 24'd100; adc_delay = 0; shim_delay = 1; stall_idx = -1;
    apply_reset();
    drive_edge();
    line_len = 16'd3; line_cnt = 16'd2; settle = 16'd4; start = 1'b1;
    wait_commits(1, "scan_first_commit");
    // Reprogramming mid-scan must not alter the grid or the settle time.
    drive_edge();
    line_len = 16'd9; line_cnt = 16'd9; settle = 16'd1;
    wait_done("scan_done");
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_fail++; $display("FAIL scan_flags: busy=%b done=%b, required busy=0 done=1", busy, done);
    end
    n_checks++;
    if ({x_pos, y_pos} !== '0) begin
      n_fail++; $display("FAIL scan_done_pos: x=%0d y=%0d, required 0 0", x_pos, y_pos);
    end
    n_checks++;
    if (rec_data.size() != 6) begin
      n_fail++; $display("FAIL scan_count: %0d samples, required 6", rec_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_data[i] !== DAT_WID'(100 + i) || rec_x[i] != i % 3 || rec_y[i] != i / 3) begin
        n_fail++;
        $display("FAIL scan_sample[%0d]: data=%0d at (%0d,%0d), required %0d at (%0d,%0d)",
                 i, rec_data[i], rec_x[i], rec_y[i], 100 + i, i % 3, i / 3);
      end
    end
    // settle=4: ADVANCE + 5 SETTLE cycles + arm edge = 7 negedges after release.
    for (int i = 1; i < 6; i++) begin
      n_checks++;
      if (gaps[i] != 7) begin
        n_fail++; $display("FAIL scan_settle_gap[%0d]: %0d cycles, required 7", i, gaps[i]);
      end
    end
    n_checks++;
    if (arm_pulses != 6 || commit_pulses != 6 || overlap_cnt != 0) begin
      n_fail++;
      $display("FAIL scan_pulses: arms=%0d commits=%0d overlaps=%0d, required 6 6 0",
               arm_pulses, commit_pulses, overlap_cnt);
    end
  endtask

  task automatic test_reset_mid_measure();
    int arm_target;
    drive_edge();
    start = 1'b0;
    tick(); tick();
    n_checks++;
    if (done !== 1'b0 || data !== 24'd105) begin
      n_fail++; $display("FAIL mm_idle: done=%b data=%0d, required 0 105", done, data);
    end
    adc_delay = 20; adc_seed = 24'hFFFFFF;
    arm_target = arm_pulses + 1;
    drive_edge();
    line_len = 16'd2; line_cnt = 16'd2; settle = 16'd2; start = 1'b1;
    wait_arms(arm_target, "mm_arm");
    tick(); tick();
    n_checks++;
    if (adc_arm !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mm_in_measure: arm=%b busy=%b, required 1 1", adc_arm, busy);
    end
    drive_edge();
    rst = 1'b0; start = 1'b0;
    drive_edge();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({x_pos, y_pos, adc_arm, data, data_commit, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL mm_reset_outputs: x=%0d y=%0d arm=%b data=%h commit=%b busy=%b done=%b, required all 0",
               x_pos, y_pos, adc_arm, data, data_commit, busy, done);
    end
    adc_delay = 0;
    drive_edge();
    line_len = 16'd1; line_cnt = 16'd1; settle = 16'd0; start = 1'b1;
    wait_done("mm_rescan_done");
    n_checks++;
    if (rec_data.size() != 1 || rec_data[0] !== 24'hFFFFFF || data !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL mm_full_scale: %0d samples, first=%h data=%h, required 1 ffffff ffffff",
               rec_data.size(), rec_data[0], data);
    end
  endtask

  task automatic test_back_pressure();
    adc_seed = 24'd100; adc_delay = 0; shim_delay = 1; stall_idx = 2; stall_len = 50;
    apply_reset();
    drive_edge();
    line_len = 16'd3; line_cnt = 16'd2; settle = 16'd4; start = 1'b1;
    wait_commits(3, "bp_third_commit");
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks++;
      if (data_commit !== 1'b1 || data !== 24'd102 || x_pos !== 16'd2 || y_pos !== 16'd0 || arm_pulses != 3) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: commit=%b data=%0d x=%0d y=%0d arms=%0d, required 1 102 2 0 3",
                 c, data_commit, data, x_pos, y_pos, arm_pulses);
      end
    end
    wait_done("bp_done");
    stall_idx = -1;
    n_checks++;
    if (rec_data.size() != 6 || arm_pulses != 6 || overlap_cnt != 0) begin
      n_fail++;
      $display("FAIL bp_count: samples=%0d arms=%0d overlaps=%0d, required 6 6 0",
               rec_data.size(), arm_pulses, overlap_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_data[i] !== DAT_WID'(100 + i)) begin
        n_fail++; $display("FAIL bp_data[%0d]: %0d, required %0d", i, rec_data[i], 100 + i);
      end
    end
  endtask

  task automatic test_abort();
    adc_seed = 24'd100; adc_delay = 0; shim_delay = 1; stall_idx = -1;
    apply_reset();
    drive_edge();
    line_len = 16'd4; line_cnt = 16'd4; settle = 16'd1; start = 1'b1;
    wait_commits(5, "abort_fifth_commit");
    // Sample 5 is mid-commit here; it must still be delivered.
    drive_edge();
    start = 1'b0;
    repeat (30) tick();
    n_checks++;
    if (rec_data.size() != 5 || rec_data[4] !== 24'd104 || rec_x[4] != 0 || rec_y[4] != 1) begin
      n_fail++;
      $display("FAIL abort_last_sample: %0d samples, last=%0d at (%0d,%0d), required 5, 104 at (0,1)",
               rec_data.size(), rec_data[4], rec_x[4], rec_y[4]);
    end
    n_checks++;
    if ({busy, done} !== 2'b00 || {x_pos, y_pos} !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b x=%0d y=%0d, required 0 0 0 0", busy, done, x_pos, y_pos);
    end
    n_checks++;
    if (arm_pulses != 5 || commit_pulses != 5) begin
      n_fail++; $display("FAIL abort_pulses: arms=%0d commits=%0d, required 5 5", arm_pulses, commit_pulses);
    end
  endtask

  task automatic test_degenerate();
    int t = 0;
    apply_reset();
    drive_edge();
    line_len = 16'd0; line_cnt = 16'd5; settle = 16'd3; start = 1'b1;
    while (done !== 1'b1 && t < 2) begin tick(); t++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL degen_done: done=%b after 2 cycles, required 1", done);
    end
    repeat (10) tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || arm_pulses != 0 || commit_pulses != 0) begin
      n_fail++;
      $display("FAIL degen_hold: done=%b busy=%b arms=%0d commits=%0d, required 1 0 0 0",
               done, busy, arm_pulses, commit_pulses);
    end
    drive_edge();
    start = 1'b0;
    tick(); tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL degen_release: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_settle_zero();
    adc_seed = 24'd100; adc_delay = 0; shim_delay = 1; stall_idx = -1;
    apply_reset();
    adc_hold_high = 1'b1;
    tick();
    drive_edge();
    line_len = 16'd2; line_cnt = 16'd1; settle = 16'd0; start = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (arm_pulses != 0 || adc_arm !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sz_stall: arms=%0d arm=%b busy=%b, required 0 0 1", arm_pulses, adc_arm, busy);
    end
    drive_edge();
    adc_hold_high = 1'b0;
    tick();
    n_checks++;
    if (arm_pulses != 0) begin
      n_fail++; $display("FAIL sz_no_early_arm: arms=%0d, required 0", arm_pulses);
    end
    tick();
    n_checks++;
    if (arm_pulses != 1) begin
      n_fail++; $display("FAIL sz_arm_after_release: arms=%0d, required 1", arm_pulses);
    end
    wait_done("sz_done");
    // settle=0: ADVANCE + 1 SETTLE cycle + arm edge = 3 negedges after release.
    n_checks++;
    if (rec_data.size() != 2 || gaps[1] != 3 || rec_data[0] !== 24'd100 || rec_data[1] !== 24'd101) begin
      n_fail++;
      $display("FAIL sz_scan: samples=%0d gap=%0d data=%0d,%0d, required 2 3 100,101",
               rec_data.size(), gaps[1], rec_data[0], rec_data[1]);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_reset_mid_measure();
    test_back_pressure();
    test_abort();
    test_degenerate();
    test_settle_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_sampler.md
Name: raster_sampler

Overview:
Raster-scan sequencer that sits directly upstream of the RAM shim. It steps X/Y position counters across a programmed grid and waits a settle time at each point. At each point it runs one ADC conversion over a 4-phase handshake, then pushes the sample to the shim over the data/data_commit/finished 4-phase handshake. Back-pressure from a full shim FIFO stalls the scan without losing samples.

Parameters:
DAT_WID, 24, sample width; equals the shim DAT_WID and the ADC result width
CNT_WID, 16, width of the X/Y position counters and of the grid dimensions
SETTLE_WID, 16, width of the settle-time counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
start  in  1  level; 1 runs a scan, 0 aborts or acknowledges done
line_len  in  CNT_WID  samples per line; latched on scan start
line_cnt  in  CNT_WID  lines per scan; latched on scan start
settle  in  SETTLE_WID  settle cycles per point; latched on scan start
x_pos  out  CNT_WID  current X index (drives X DAC)
y_pos  out  CNT_WID  current Y index (drives Y DAC)
adc_arm  out  1  ADC conversion request
adc_finished  in  1  ADC conversion done
adc_data  in  DAT_WID  ADC result; valid while adc_finished=1
data  out  DAT_WID  sample to shim
data_commit  out  1  shim write request
finished  in  1  shim write acknowledge
busy  out  1  scan in progress
done  out  1  scan completed normally

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; x_pos=0, y_pos=0, adc_arm=0, data=0, data_commit=0, busy=0, done=0. Reset is honoured in every state, including mid-handshake.
- IDLE: if start=1 and done=0 -> latch line_len, line_cnt, settle; clear x_pos/y_pos; busy<=1; go to SETTLE with the settle counter loaded to `settle`.
- IDLE, degenerate grid: if line_len==0 or line_cnt==0 at start -> go straight to DONE. No ADC or shim traffic.
- SETTLE: decrement the counter each cycle; leave when it reaches 0. With settle=0 the block spends exactly 1 cycle in SETTLE.
- SETTLE -> MEASURE: go to MEASURE only if adc_finished=0; otherwise stall in SETTLE.
- MEASURE: adc_arm=1. On adc_finished=1: latch data<=adc_data, adc_arm<=0, go to MEAS_RELEASE.
- MEAS_RELEASE: wait for adc_finished=0, then data_commit<=1 and go to COMMIT.
- COMMIT: hold data and data_commit=1 until finished=1. Stall indefinitely while the shim FIFO is full. On finished=1: data_commit<=0, go to COMMIT_RELEASE.
- COMMIT_RELEASE: wait for finished=0, then go to ADVANCE.
- ADVANCE, mid-line: if x_pos != line_len-1 -> x_pos+1.
- ADVANCE, end of line: else x_pos<=0 and y_pos+1. If y_pos == line_cnt-1 -> go to DONE; otherwise reload the settle counter and go to SETTLE.
- ADVANCE, position outputs: x_pos/y_pos change only in ADVANCE, so DAC outputs are stable for the whole settle, measure and commit of a point.
- DONE: busy=0, done=1, x_pos=y_pos=0. Stay until start=0, then done<=0 and return to IDLE. A new scan needs a 0->1 transition of start.
- Abort (start=0 while busy): checked only in SETTLE and ADVANCE. Never break an ADC or shim handshake midway; the in-flight sample is committed. On abort go to IDLE with busy=0, done=0, positions cleared.
- Handshake outputs: adc_arm and data_commit are registered and never both high in the same cycle.
- Sample count: a normal scan commits exactly line_len*line_cnt samples, in raster order (X fastest).
- Input changes: changes to line_len, line_cnt or settle while busy have no effect.
- Arithmetic: all counters are unsigned. Comparisons use the latched values minus 1, computed at CNT_WID bits. The zero check at start prevents underflow.

Test Plan:
- Grid line_len=3, line_cnt=2, settle=4; ADC returns 100+n on the nth conversion; shim acks 1 cycle after commit -> 6 commits, data 100..105, (x,y) sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); done=1 and busy=0 after the last ack; 5 cycles in SETTLE per point.
- Back-pressure: same grid, shim holds finished=0 for 50 cycles on the 3rd sample -> data_commit stays 1 and data stable at 102; x_pos stays 2; no further ADC arm; the scan then completes with 6 samples.
- Abort: line_len=4, line_cnt=4; drop start while in COMMIT of sample 5 -> sample 5 committed, then IDLE with busy=0, done=0, x_pos=y_pos=0; no 6th adc_arm.
- Degenerate: line_len=0, line_cnt=5 -> done=1 within 2 cycles; zero adc_arm and data_commit pulses. Hold start=1 and confirm no restart; drop start -> done=0.
- Reset mid-MEASURE (rst=0 one cycle) -> next cycle all outputs at reset values; ADC 24-bit value 0xFFFFFF is passed to data unmodified on the next scan.
- Settle=0 with adc_finished held 1 at entry -> no adc_arm until adc_finished falls; each point then spends exactly 1 cycle in SETTLE.
